date_counter: RTL and testbench
===============================

# date_counter

Calendar stage of the clock system, directly downstream of the time-of-day counter. Consumes the single-cycle midnight-rollover tick and advances a day/month/year register set covering years 2000–2099, including month lengths and leap years. Accepts validated user set commands from the switch/key front end. Presents binary and BCD date values to the display multiplexer.

## Interface
Parameters:
- `RESET_DAY`, default 1: day value loaded on reset (1–31).
- `RESET_MONTH`, default 1: month value loaded on reset (1–12).
- `RESET_YEAR`, default 0: year value loaded on reset (0–99, meaning 2000–2099).

Ports:
- `CK50M` in 1: system clock. One clock domain only.
- `RST` in 1: reset, asynchronous, active-high.
- `day_tick` in 1: single-cycle pulse from the time counter on 23:59:59→00:00:00.
- `set_en` in 1: single-cycle set strobe (KEY0 falling edge, date mode, already synchronised/debounced).
- `set_field` in 2: 2'b01 day, 2'b10 month, 2'b11 year, 2'b00 none.
- `set_value` in 7: binary value to load (SW[6:0]).
- `day` out 5: binary day, 1–31.
- `month` out 4: binary month, 1–12.
- `year` out 7: binary year, 0–99.
- `day_bcd` out 8, `month_bcd` out 8, `year_bcd` out 8: two-digit BCD of the above, tens in [7:4].
- `set_err` out 1: single-cycle pulse when a set command is rejected.
- `year_wrap` out 1: single-cycle pulse when the year rolls 99→0.

## Operation
- Month length: months 4, 6, 9, 11 have 30 days. Month 2 has 29 days if year[1:0]==0, otherwise 28. All other months have 31.
- `day_tick` processing:
  - If day < mlen: day+1.
  - If day == mlen: day=1 and month+1.
  - If month was 12: month=1 and year+1.
  - If year was 99: year=0 and `year_wrap` pulses.
- Set day: accepted if 1 ≤ value ≤ mlen(month, year). Otherwise no change and `set_err` pulses.
- Set month: accepted if 1 ≤ value ≤ 12. If the current day exceeds the new month's length, day is clamped to that length in the same cycle.
- Set year: accepted if value ≤ 99. If month==2, day==29 and the new year is not leap, day is clamped to 28.
- `set_en` with `set_field`==00: ignored, no `set_err`.
- `set_en` and `day_tick` in the same cycle: the set command wins and the tick is discarded. A rejected set also discards the tick.
- Every update is computed from current register values only. The next-state logic must never produce day 0, day > mlen, month 0 or month > 12.

## Timing
- All outputs are registered. Reset values: day=`RESET_DAY`, month=`RESET_MONTH`, year=`RESET_YEAR`, BCD outputs equal to the BCD of those values, `set_err`=0, `year_wrap`=0.
- Binary outputs update on the first `CK50M` edge after the tick or strobe is sampled high (latency 1).
- BCD outputs pass through one further register (latency 2 from the event).
- `set_err` and `year_wrap` assert in the same cycle as the binary update, for exactly one cycle.
- Back-to-back ticks or strobes on consecutive cycles are each processed. There is no busy state and no backpressure.
- Reset asserted mid-operation forces the reset values asynchronously. The first event is honoured on the first edge after deassertion.

## Structure
- Shared package `clock_pkg` holds:
  - Field encodings `FLD_NONE`/`FLD_DAY`/`FLD_MONTH`/`FLD_YEAR`. The time counter's `FLD_SEC`/`FLD_MIN`/`FLD_HOUR` use the same code points.
  - Limits `MAX_MONTH`=12 and `MAX_YEAR`=99.
  - Function `month_len(month, year)`.
- Sub-module `bin2bcd7`: registered 7-bit binary to 8-bit two-digit BCD (0–99), one cycle of latency, async reset to 0x00 overridden by parameter. Instantiated three times.
- Core: one next-state always block for day/month/year/flags, plus the `bin2bcd7` instances.

## Test plan
- Reset, then 31 ticks from 01/01/00: day=1, month=2, year=0. `day_bcd`=0x01 two cycles after the last tick.
- Set 28/02/23, one tick: 01/03/23. Set year 24 and day 28 in month 2, one tick: 29/02/24; next tick: 01/03/24.
- Set 31/12/99, one tick: 01/01/00 with a `year_wrap` pulse of exactly one cycle.
- Set day 31 while month=4: `set_err` pulses and day is unchanged. Set month 13: `set_err` pulses. Set value with field 00: nothing changes and no error.
- Set 31/01/25, then set month 2: day clamps to 28. Set 29/02/24, then set year 25: day clamps to 28.
- `day_tick` coincident with `set_en` (day=15): day=15 with no increment. Assert `RST` mid-sequence: 01/01/00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock system: set-field code points, calendar
// limits and the month-length rule used by the date counter.
package clock_pkg;

  localparam logic [1:0] FLD_NONE  = 2'b00;
  localparam logic [1:0] FLD_DAY   = 2'b01;
  localparam logic [1:0] FLD_MONTH = 2'b10;
  localparam logic [1:0] FLD_YEAR  = 2'b11;

  // Time-counter fields reuse the same code points as the date fields.
  localparam logic [1:0] FLD_SEC   = FLD_DAY;
  localparam logic [1:0] FLD_MIN   = FLD_MONTH;
  localparam logic [1:0] FLD_HOUR  = FLD_YEAR;

  localparam logic [3:0] MAX_MONTH = 4'd12;
  localparam logic [6:0] MAX_YEAR  = 7'd99;

  // Days in a month; year counts 2000-2099 so year%4==0 is exactly the leap rule.
  function automatic logic [4:0] month_len(input logic [3:0] month, input logic [6:0] year);
    logic [4:0] len;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/bin2bcd7.sv
// Registered 7-bit binary to two-digit BCD converter (valid for 0-99).
module bin2bcd7 #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       CK50M,
  input  logic       RST,
  input  logic [6:0] bin,
  output logic [7:0] bcd
);

  logic [7:0] bcd_d, bcd_q;

  always_comb begin
    bcd_d = {4'(bin / 7'd10), 4'(bin % 7'd10)};
  end

  always_ff @(posedge CK50M or posedge RST) begin
    if (RST) bcd_q <= RESET_VAL;
    else     bcd_q <= bcd_d;
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/date_counter.sv
// Calendar day/month/year counter for 2000-2099 with set commands,
// driven by the midnight tick; binary outputs plus one-cycle-later BCD.
module date_counter
  import clock_pkg::*;
#(
  parameter int unsigned RESET_DAY   = 1,
  parameter int unsigned RESET_MONTH = 1,
  parameter int unsigned RESET_YEAR  = 0
) (
  input  logic       CK50M,
  input  logic       RST,
  input  logic       day_tick,
  input  logic       set_en,
  input  logic [1:0] set_field,
  input  logic [6:0] set_value,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic [7:0] day_bcd,
  output logic [7:0] month_bcd,
  output logic [7:0] year_bcd,
  output logic       set_err,
  output logic       year_wrap
);

  localparam logic [7:0] DAY_BCD_RST   = {4'(RESET_DAY / 10),   4'(RESET_DAY % 10)};
  localparam logic [7:0] MONTH_BCD_RST = {4'(RESET_MONTH / 10), 4'(RESET_MONTH % 10)};
  localparam logic [7:0] YEAR_BCD_RST  = {4'(RESET_YEAR / 10),  4'(RESET_YEAR % 10)};

  logic [4:0] day_d, day_q;
  logic [3:0] month_d, month_q;
  logic [6:0] year_d, year_q;
  logic       set_err_d, set_err_q;
  logic       year_wrap_d, year_wrap_q;
  logic [4:0] cur_len, new_len;

  // Next-state: a real set command (accepted or rejected) pre-empts the tick.
  always_comb begin
    day_d       = day_q;
    month_d     = month_q;
    year_d      = year_q;
    set_err_d   = 1'b0;
    year_wrap_d = 1'b0;
    cur_len     = month_len(month_q, year_q);
    new_len     = cur_len;

    if (set_en && (set_field != FLD_NONE)) begin
      case (set_field)
        FLD_DAY: begin
          if ((set_value != 7'd0) && (set_value <= {2'b00, cur_len})) day_d = set_value[4:0];
          else                                                        set_err_d = 1'b1;
        end
        FLD_MONTH: begin
          if ((set_value != 7'd0) && (set_value <= {3'b000, MAX_MONTH})) begin
            month_d = set_value[3:0];
            new_len = month_len(set_value[3:0], year_q);
            if (day_q > new_len) day_d = new_len;
          end else begin
            set_err_d = 1'b1;
          end
        end
        FLD_YEAR: begin
          if (set_value <= MAX_YEAR) begin
            year_d  = set_value;
            new_len = month_len(month_q, set_value);
            if (day_q > new_len) day_d = new_len;
          end else begin
            set_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (day_tick) begin
      if (day_q < cur_len) begin
        day_d = day_q + 5'd1;
      end else begin
        day_d = 5'd1;
        if (month_q < MAX_MONTH) begin
          month_d = month_q + 4'd1;
        end else begin
          month_d = 4'd1;
          if (year_q < MAX_YEAR) begin
            year_d = year_q + 7'd1;
          end else begin
            year_d      = 7'd0;
            year_wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CK50M or posedge RST) begin
    if (RST) begin
      day_q       <= 5'(RESET_DAY);
      month_q     <= 4'(RESET_MONTH);
      year_q      <= 7'(RESET_YEAR);
      set_err_q   <= 1'b0;
      year_wrap_q <= 1'b0;
    end else begin
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      set_err_q   <= set_err_d;
      year_wrap_q <= year_wrap_d;
    end
  end

  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign set_err   = set_err_q;
  assign year_wrap = year_wrap_q;

  bin2bcd7 #(.RESET_VAL(DAY_BCD_RST)) u_day_bcd (
    .CK50M(CK50M), .RST(RST), .bin({2'b00, day_q}), .bcd(day_bcd)
  );

  bin2bcd7 #(.RESET_VAL(MONTH_BCD_RST)) u_month_bcd (
    .CK50M(CK50M), .RST(RST), .bin({3'b000, month_q}), .bcd(month_bcd)
  );

  bin2bcd7 #(.RESET_VAL(YEAR_BCD_RST)) u_year_bcd (
    .CK50M(CK50M), .RST(RST), .bin(year_q), .bcd(year_bcd)
  );

endmodule

// File: tb/tb_date_counter.sv
// Bench for date_counter: directed calendar scenarios plus random ticks/sets
// checked against a plain-arithmetic calendar model.
module tb_date_counter;

  logic       CK50M = 1'b0;
  logic       RST;
  logic       day_tick, set_en;
  logic [1:0] set_field;
  logic [6:0] set_value;
  logic [4:0] day;
  logic [3:0] month;
  logic [6:0] year;
  logic [7:0] day_bcd, month_bcd, year_bcd;
  logic       set_err, year_wrap;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: current date, date one edge earlier (feeds BCD), and flags.
  int m_d, m_m, m_y, p_d, p_m, p_y, m_err, m_wrap;

  date_counter dut (
    .CK50M(CK50M), .RST(RST), .day_tick(day_tick), .set_en(set_en),
    .set_field(set_field), .set_value(set_value), .day(day), .month(month),
    .year(year), .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
    .set_err(set_err), .year_wrap(year_wrap)
  );

  always #10 CK50M = ~CK50M;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  function automatic int days_in(input int m, input int y);
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    return 31;
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic void model_reset();
    m_d = 1; m_m = 1; m_y = 0; p_d = 1; p_m = 1; p_y = 0; m_err = 0; m_wrap = 0;
  endfunction

  function automatic void model_step(input bit tk, input bit en, input int fld, input int val);
    m_err = 0; m_wrap = 0;
    if (en && fld != 0) begin
      if (fld == 1) begin
        if (val >= 1 && val <= days_in(m_m, m_y)) m_d = val; else m_err = 1;
      end else if (fld == 2) begin
        if (val >= 1 && val <= 12) begin
          m_m = val;
          if (m_d > days_in(m_m, m_y)) m_d = days_in(m_m, m_y);
        end else m_err = 1;
      end else begin
        if (val <= 99) begin
          m_y = val;
          if (m_d > days_in(m_m, m_y)) m_d = days_in(m_m, m_y);
        end else m_err = 1;
      end
    end else if (tk) begin
      if (m_d < days_in(m_m, m_y)) m_d++;
      else begin
        m_d = 1;
        if (m_m < 12) m_m++;
        else begin
          m_m = 1;
          if (m_y < 99) m_y++;
          else begin m_y = 0; m_wrap = 1; end
        end
      end
    end
  endfunction

  task automatic check_all();
    check_eq("day", int'(day), m_d);
    check_eq("month", int'(month), m_m);
    check_eq("year", int'(year), m_y);
    check_eq("set_err", int'(set_err), m_err);
    check_eq("year_wrap", int'(year_wrap), m_wrap);
    check_eq("day_bcd", int'(day_bcd), to_bcd(p_d));
    check_eq("month_bcd", int'(month_bcd), to_bcd(p_m));
    check_eq("year_bcd", int'(year_bcd), to_bcd(p_y));
  endtask

  // One clock cycle with the given inputs; outputs checked 1 time unit after the edge.
  task automatic step(input bit tk, input bit en, input logic [1:0] fld, input logic [6:0] val);
    @(negedge CK50M);
    day_tick = tk; set_en = en; set_field = fld; set_value = val;
    p_d = m_d; p_m = m_m; p_y = m_y;
    model_step(tk, en, int'(fld), int'(val));
    @(posedge CK50M);
    #1;
    day_tick = 1'b0; set_en = 1'b0; set_field = 2'b00; set_value = 7'd0;
    check_all();
  endtask

  task automatic set_date(input int d, input int m, input int y);
    step(0, 1, 2'b11, 7'(y));
    step(0, 1, 2'b10, 7'(m));
    step(0, 1, 2'b01, 7'(d));
  endtask

  initial begin
    RST = 1'b1; day_tick = 1'b0; set_en = 1'b0; set_field = 2'b00; set_value = 7'd0;
    model_reset();
    #5;
    check_all();
    @(negedge CK50M);
    RST = 1'b0;

    // 31 ticks from 01/01/00 lands on 01/02/00
    for (int i = 0; i < 31; i++) step(1, 0, 2'b00, 7'd0);
    check_eq("jan31_day", int'(day), 1);
    check_eq("jan31_month", int'(month), 2);
    step(0, 0, 2'b00, 7'd0);
    check_eq("jan31_day_bcd", int'(day_bcd), 8'h01);
    check_eq("jan31_month_bcd", int'(month_bcd), 8'h02);

    set_date(28, 2, 23);
    step(1, 0, 2'b00, 7'd0);
    check_eq("feb23_day", int'(day), 1);
    check_eq("feb23_month", int'(month), 3);
    step(0, 1, 2'b11, 7'd24);
    step(0, 1, 2'b10, 7'd2);
    step(0, 1, 2'b01, 7'd28);
    step(1, 0, 2'b00, 7'd0);
    check_eq("leap_day29", int'(day), 29);
    step(1, 0, 2'b00, 7'd0);
    check_eq("leap_mar_day", int'(day), 1);
    check_eq("leap_mar_month", int'(month), 3);

    set_date(31, 12, 99);
    step(1, 0, 2'b00, 7'd0);
    check_eq("wrap_pulse", int'(year_wrap), 1);
    check_eq("wrap_year", int'(year), 0);
    step(0, 0, 2'b00, 7'd0);
    check_eq("wrap_single", int'(year_wrap), 0);

    set_date(10, 4, 5);
    step(0, 1, 2'b01, 7'd31);
    check_eq("apr31_err", int'(set_err), 1);
    check_eq("apr31_day", int'(day), 10);
    step(0, 1, 2'b10, 7'd13);
    check_eq("month13_err", int'(set_err), 1);
    step(0, 1, 2'b10, 7'd0);
    step(0, 1, 2'b01, 7'd0);
    step(0, 1, 2'b11, 7'd100);
    step(0, 1, 2'b00, 7'd7);
    check_eq("fld_none_err", int'(set_err), 0);

    set_date(31, 1, 25);
    step(0, 1, 2'b10, 7'd2);
    check_eq("clamp_month", int'(day), 28);
    set_date(29, 2, 24);
    step(0, 1, 2'b11, 7'd25);
    check_eq("clamp_year", int'(day), 28);

    step(0, 1, 2'b01, 7'd15);
    step(1, 1, 2'b01, 7'd15);
    check_eq("tick_vs_set", int'(day), 15);
    step(1, 1, 2'b01, 7'd31);
    check_eq("tick_vs_bad_set", int'(day), 15);

    // Asynchronous reset away from any clock edge
    step(1, 0, 2'b00, 7'd0);
    @(negedge CK50M);
    #3 RST = 1'b1;
    #1;
    model_reset();
    check_eq("async_rst_day", int'(day), 1);
    check_eq("async_rst_month", int'(month), 1);
    check_eq("async_rst_year", int'(year), 0);
    check_eq("async_rst_bcd", int'(day_bcd), 8'h01);
    @(negedge CK50M);
    RST = 1'b0;
    step(1, 0, 2'b00, 7'd0);
    check_eq("post_rst_tick", int'(day), 2);

    // Random mix of ticks and set commands
    for (int i = 0; i < 3000; i++) begin
      bit         tk, en;
      logic [1:0] fld;
      logic [6:0] val;
      tk  = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 7) == 0);
      fld = 2'($urandom_range(0, 3));
      case (fld)
        2'b01:   val = 7'($urandom_range(0, 33));
        2'b10:   val = 7'($urandom_range(0, 14));
        default: val = 7'($urandom_range(0, 127));
      endcase
      if (en && fld == 2'b00) tk = 1'b0;
      step(tk, en, fld, val);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
